// File: rtl/imem_fetch_if.sv
// Fetch-side bus: instruction memory read port, decode handshake, redirect/halt control.
// The fetch_fault signal exists only when IFETCH_MISALIGN_TRAP_EN is defined.
interface imem_fetch_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned INS_W  = 32,
  parameter int unsigned CNT_W  = 32
);
  logic [ADDR_W-1:0] mem_ra;
  logic [INS_W-1:0]  mem_rd;
  logic              inst_valid;
  logic              inst_ready;
  logic [INS_W-1:0]  inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic              fetch_fault;

  modport master (
    output mem_ra, inst_valid, inst_data, inst_pc, halted, fetch_cnt, fetch_fault,
    input  mem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
  );
  modport slave (
    input  mem_ra, inst_valid, inst_data, inst_pc, halted, fetch_cnt, fetch_fault,
    output mem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
  );
`else
  modport master (
    output mem_ra, inst_valid, inst_data, inst_pc, halted, fetch_cnt,
    input  mem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
  );
  modport slave (
    input  mem_ra, inst_valid, inst_data, inst_pc, halted, fetch_cnt,
    output mem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
  );
`endif
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, aligns 1-cycle memory data with its PC, serves decode.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned INS_W    = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  imem_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC) & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic              fetch_fault_q, fetch_fault_d;
`endif

  logic              redirect_c;
  logic              stall_c;
  logic              accept_c;
  logic [ADDR_W-1:0] mem_ra_c;
  logic [ADDR_W-1:0] redirect_tgt_c;
  logic [INS_W-1:0]  inst_data_c;

  // Redirect is ignored during the boot cycle; it always beats stall and halt otherwise.
  assign redirect_c     = bus.redirect_valid & (state_q != S_BOOT);
  assign stall_c        = pend_valid_q & ~bus.inst_ready;
  assign accept_c       = pend_valid_q & ~bus.redirect_valid & bus.inst_ready;
  assign redirect_tgt_c = bus.redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fetch_cnt_d  = accept_c ? fetch_cnt_q + CNT_W'(1) : fetch_cnt_q;
    mem_ra_c     = fetch_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    fetch_fault_d = fetch_fault_q;
`endif

    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // While stalled, re-read the pending word so mem_rd stays stable.
        if (stall_c) begin
          mem_ra_c = pend_pc_q;
        end else if (bus.halt_req) begin
          pend_valid_d = 1'b0;
          state_d      = S_HALT;
        end else begin
          pend_valid_d = 1'b1;
          pend_pc_d    = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + PC_STEP;
        end
      end
      S_HALT:  pend_valid_d = 1'b0;
      default: state_d = S_BOOT;
    endcase

    if (redirect_c) begin
      pend_valid_d = 1'b0;
      pend_pc_d    = pend_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (|bus.redirect_pc[1:0]) begin
        fetch_fault_d = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        state_d       = S_HALT;
      end else begin
        fetch_fault_d = 1'b0;
        fetch_pc_d    = redirect_tgt_c;
        state_d       = S_RUN;
      end
`else
      fetch_pc_d = redirect_tgt_c;
      state_d    = S_RUN;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= PC_RST;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      fetch_cnt_q  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_fault_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_fault_q <= fetch_fault_d;
`endif
    end
  end

  assign inst_data_c    = bus.mem_rd;
  assign bus.mem_ra     = mem_ra_c;
  assign bus.inst_valid = pend_valid_q & ~bus.redirect_valid;
  assign bus.inst_data  = inst_data_c;
  assign bus.inst_pc    = pend_pc_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.fetch_cnt  = fetch_cnt_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign bus.fetch_fault = fetch_fault_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, corner sequences, randomized stream vs. PC-stream model.
module tb_imem_fetch_ctrl;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned INS_W  = 32;
  localparam int unsigned CNT_W  = 32;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [8:0]  rpc;
    bit          hlt;
    bit          v;
    logic [8:0]  pc;
    bit          cra;
    logic [8:0]  ra;
    bit          hd;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_W(ADDR_W), .INS_W(INS_W), .CNT_W(CNT_W)) bus ();

  imem_fetch_ctrl #(
    .ADDR_W(ADDR_W), .INS_W(INS_W), .RESET_PC(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] mem [128];
  always @(posedge clk) bus.mem_rd <= mem[bus.mem_ra[8:2]];

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[$];

  function automatic logic [31:0] word_of(input logic [8:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic void add(input bit rst, input bit rdy, input bit rv, input logic [8:0] rpc,
                              input bit hlt, input bit v, input logic [8:0] pc, input bit cra,
                              input logic [8:0] ra, input bit hd, input logic [31:0] cnt);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.hlt = hlt;
    t.v = v; t.pc = pc; t.cra = cra; t.ra = ra; t.hd = hd; t.cnt = cnt;
    vecs.push_back(t);
  endfunction

  task automatic drive(input bit rst, input bit rdy, input bit rv, input logic [8:0] rpc, input bit hlt);
    reset              = rst;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt_req       = hlt;
  endtask

  // One cycle: inputs change just after the edge, outputs are sampled mid-cycle.
  task automatic cyc(input bit rst, input bit rdy, input bit rv, input logic [8:0] rpc, input bit hlt);
    @(posedge clk);
    #1;
    drive(rst, rdy, rv, rpc, hlt);
    @(negedge clk);
  endtask

  logic [8:0]  m_pc;
  int unsigned m_cnt;
  bit          p_valid, p_rdy, p_acc, rv_d1, rv_d2;
  logic [8:0]  p_pc;
  logic [31:0] p_data;
  bit          r_rdy, r_rv;
  logic [8:0]  r_rpc;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = word_of(9'(i * 4));

    // rst rdy rv rpc hlt | v pc cra ra hd cnt
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h000,0,0);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h000,0,0);
    add(0,1,0,9'h000,0, 1,9'h000,1,9'h004,0,0);
    add(0,1,0,9'h000,0, 1,9'h004,1,9'h008,0,1);
    add(0,1,0,9'h000,0, 1,9'h008,1,9'h00C,0,2);
    add(1,1,0,9'h000,0, 1,9'h00C,1,9'h010,0,3);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h000,0,0);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h000,0,0);
    add(0,1,0,9'h000,0, 1,9'h000,1,9'h004,0,0);
    add(0,0,0,9'h000,0, 1,9'h004,1,9'h004,0,1);
    add(0,0,0,9'h000,0, 1,9'h004,1,9'h004,0,1);
    add(0,0,0,9'h000,0, 1,9'h004,1,9'h004,0,1);
    add(0,1,0,9'h000,0, 1,9'h004,1,9'h008,0,1);
    add(0,1,0,9'h000,0, 1,9'h008,1,9'h00C,0,2);
    add(0,1,0,9'h000,0, 1,9'h00C,1,9'h010,0,3);
    add(0,1,1,9'h040,0, 0,9'h000,0,9'h000,0,4);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h040,0,4);
    add(0,1,0,9'h000,0, 1,9'h040,1,9'h044,0,4);
    add(0,1,1,9'h020,0, 0,9'h000,0,9'h000,0,5);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h020,0,5);
    add(0,0,0,9'h000,1, 1,9'h020,1,9'h020,0,5);
    add(0,0,0,9'h000,1, 1,9'h020,1,9'h020,0,5);
    add(0,1,0,9'h000,1, 1,9'h020,0,9'h000,0,5);
    add(0,1,0,9'h000,1, 0,9'h000,1,9'h024,1,6);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h024,1,6);
    add(0,1,1,9'h100,0, 0,9'h000,0,9'h000,1,6);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h100,0,6);
    add(0,1,0,9'h000,0, 1,9'h100,1,9'h104,0,6);
    add(0,1,1,9'h1F8,0, 0,9'h000,0,9'h000,0,7);
    add(0,1,0,9'h000,0, 0,9'h000,1,9'h1F8,0,7);
    add(0,1,0,9'h000,0, 1,9'h1F8,1,9'h1FC,0,7);
    add(0,1,0,9'h000,0, 1,9'h1FC,1,9'h000,0,8);
    add(0,1,0,9'h000,0, 1,9'h000,1,9'h004,0,9);

    // Reset values
    drive(1, 0, 0, 9'h000, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  32'(bus.inst_valid), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_cnt",    bus.fetch_cnt, 0);
    chk("rst_ra",     32'(bus.mem_ra), 0);
    chk("rst_pc",     32'(bus.inst_pc), 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst_fault",  32'(bus.fetch_fault), 0);
`endif

    foreach (vecs[k]) begin
      cyc(vecs[k].rst, vecs[k].rdy, vecs[k].rv, vecs[k].rpc, vecs[k].hlt);
      chk($sformatf("tbl%0d_valid", k),  32'(bus.inst_valid), 32'(vecs[k].v));
      chk($sformatf("tbl%0d_halted", k), 32'(bus.halted), 32'(vecs[k].hd));
      chk($sformatf("tbl%0d_cnt", k),    bus.fetch_cnt, vecs[k].cnt);
      if (vecs[k].v) begin
        chk($sformatf("tbl%0d_pc", k),   32'(bus.inst_pc), 32'(vecs[k].pc));
        chk($sformatf("tbl%0d_data", k), bus.inst_data, word_of(vecs[k].pc));
      end
      if (vecs[k].cra) chk($sformatf("tbl%0d_ra", k), 32'(bus.mem_ra), 32'(vecs[k].ra));
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk($sformatf("tbl%0d_fault", k), 32'(bus.fetch_fault), 0);
`endif
    end

    // Misaligned redirect target
    cyc(0, 1, 1, 9'h042, 0);
    chk("mis_valid0", 32'(bus.inst_valid), 0);
    chk("mis_cnt0",   bus.fetch_cnt, 10);
`ifdef IFETCH_MISALIGN_TRAP_EN
    cyc(0, 1, 0, 9'h000, 0);
    chk("mis_fault1",  32'(bus.fetch_fault), 1);
    chk("mis_halted1", 32'(bus.halted), 1);
    chk("mis_valid1",  32'(bus.inst_valid), 0);
    cyc(0, 1, 1, 9'h044, 0);
    chk("mis_fault_hold", 32'(bus.fetch_fault), 1);
    cyc(0, 1, 0, 9'h000, 0);
    chk("mis_fault_clr",  32'(bus.fetch_fault), 0);
    chk("mis_halted_clr", 32'(bus.halted), 0);
    chk("mis_ra44",       32'(bus.mem_ra), 32'h044);
    cyc(0, 1, 0, 9'h000, 0);
    chk("mis_valid44", 32'(bus.inst_valid), 1);
    chk("mis_pc44",    32'(bus.inst_pc), 32'h044);
    chk("mis_data44",  bus.inst_data, word_of(9'h044));
`else
    cyc(0, 1, 0, 9'h000, 0);
    chk("mis_ra40",     32'(bus.mem_ra), 32'h040);
    chk("mis_halted",   32'(bus.halted), 0);
    cyc(0, 1, 0, 9'h000, 0);
    chk("mis_valid40",  32'(bus.inst_valid), 1);
    chk("mis_pc40",     32'(bus.inst_pc), 32'h040);
    chk("mis_data40",   bus.inst_data, word_of(9'h040));
`endif

    // Randomized stream: model is the ordered sequence of PCs decode must accept
    cyc(1, 0, 0, 9'h000, 0);
    cyc(1, 0, 0, 9'h000, 0);
    m_pc = 9'h000; m_cnt = 0;
    p_valid = 0; p_rdy = 0; p_acc = 0; rv_d1 = 0; rv_d2 = 0; p_pc = '0; p_data = '0;
    for (int i = 0; i < 3000; i++) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = (i >= 1) && ($urandom_range(0, 19) == 0);
      r_rpc = 9'($urandom_range(0, 511));
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_rpc[1:0] = 2'b00;
`endif
      cyc(0, r_rdy, r_rv, r_rpc, 0);
      chk("rand_cnt", bus.fetch_cnt, 32'(m_cnt));
      if (r_rv) begin
        chk("rand_redirect_kill", 32'(bus.inst_valid), 0);
      end else begin
        chk("rand_ra_aligned", 32'(bus.mem_ra[1:0]), 0);
        if (p_valid && !p_rdy) begin
          chk("rand_stall_valid", 32'(bus.inst_valid), 1);
          chk("rand_stall_pc",    32'(bus.inst_pc), 32'(p_pc));
          chk("rand_stall_data",  bus.inst_data, p_data);
          if (!r_rdy) chk("rand_stall_ra", 32'(bus.mem_ra), 32'(p_pc));
        end
        if (p_acc) chk("rand_no_bubble", 32'(bus.inst_valid), 1);
        if (rv_d2 && !rv_d1) chk("rand_redirect_latency", 32'(bus.inst_valid), 1);
      end
      if (bus.inst_valid && r_rdy) begin
        chk("rand_pc",   32'(bus.inst_pc), 32'(m_pc));
        chk("rand_data", bus.inst_data, word_of(bus.inst_pc));
        m_pc  = m_pc + 9'd4;
        m_cnt = m_cnt + 1;
      end
      if (r_rv) m_pc = r_rpc & 9'h1FC;
      p_acc   = bus.inst_valid && r_rdy;
      p_valid = bus.inst_valid;
      p_rdy   = r_rdy;
      p_pc    = bus.inst_pc;
      p_data  = bus.inst_data;
      rv_d2   = rv_d1;
      rv_d1   = r_rv;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the instruction memory: owns the program counter, drives the memory read address, and aligns the memory's 1-cycle registered read data with its PC.
- Presents instructions to decode over a valid/ready handshake; handles stall, redirect (branch/jump), halt/resume and a retired-fetch counter.
- Sits between the instruction memory (read-only, registered output, word index = ra[ADDR_W-1:2]) and decode.

Parameters:
- ADDR_W, 9, byte-address width of the instruction memory.
- INS_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset; must be word-aligned.
- CNT_W, 32, width of the accepted-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high reset.
- mem_ra  out  ADDR_W  read address to instruction memory; bits [1:0] always 0.
- mem_rd  in  INS_W  registered read data from memory; valid 1 cycle after mem_ra.
- inst_valid  out  1  inst_data/inst_pc hold a fetched instruction.
- inst_ready  in  1  decode accepts when inst_valid & inst_ready.
- inst_data  out  INS_W  instruction; equals mem_rd when valid.
- inst_pc  out  ADDR_W  byte address of inst_data.
- redirect_valid  in  1  load new PC, flush in-flight fetch.
- redirect_pc  in  ADDR_W  redirect target.
- halt_req  in  1  stop launching fetches (ecall/ebreak/debug).
- halted  out  1  high in S_HALT.
- fetch_cnt  out  CNT_W  count of accepted instructions.

Behaviour:
- Registers: fetch_pc (next address to launch), pend_valid and pend_pc (describe the current mem_rd), state, fetch_cnt.
- Reset (sync): fetch_pc=RESET_PC, pend_valid=0, pend_pc=0, fetch_cnt=0, state=S_BOOT. All outputs read 0 except mem_ra=RESET_PC.
- inst_valid = pend_valid & !redirect_valid. inst_data = mem_rd. inst_pc = pend_pc.
- stall = pend_valid & !inst_ready.
- mem_ra is combinational: pend_pc when stall, otherwise fetch_pc when launching. While stalled, the memory re-reads the same word, so the data stays stable. The inst_ready->mem_ra combinational path is intended.
- States:
  - S_BOOT: one cycle; no fetch launched; mem_ra=RESET_PC; goes to S_RUN. The first instruction is valid 2 cycles after reset deasserts.
  - S_RUN, no stall and no redirect: launch. pend_valid<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - S_RUN, stall: fetch_pc and pend_* hold.
  - S_RUN, halt_req (redirect low): no launch. The pending instruction is held until accepted, then pend_valid<=0. Goes to S_HALT.
  - S_HALT: mem_ra=fetch_pc, pend_valid=0, halted=1. halt_req is ignored. Exits only on redirect_valid.
- Redirect (any state except S_BOOT) has highest priority over stall and halt:
  - fetch_pc<=redirect_pc & ~3, pend_valid<=0, state<=S_RUN.
  - The in-flight instruction is discarded and not counted.
  - Redirect in cycle T gives inst_valid=1 with inst_pc=target at T+2.
  - Back-to-back redirects: the last one wins.
- Throughput: 1 instruction/cycle while inst_ready=1, with no bubbles.
- Wrap-around: fetch_pc+4 is modulo 2^ADDR_W; 0x1FC is followed by 0x000 with no flag.
- fetch_cnt increments on each inst_valid & inst_ready and wraps modulo 2^CNT_W.
- Reset mid-stream or mid-redirect: everything returns to the reset values next cycle; the pending instruction is lost.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 does not load the PC. Instead: fetch_fault<=1, pend_valid<=0, state<=S_HALT.
  - fetch_fault clears on the next aligned redirect or on reset.
- When undefined: the low bits are silently cleared and no port is added.

Test Plan:
- Reset then inst_ready=1 held, memory preloaded with words at 0x000/0x004/0x008 -> inst_valid rises on the 2nd cycle after reset; inst_pc 0x000, 0x004, 0x008 on consecutive cycles; fetch_cnt=3.
- inst_ready=0 for 3 cycles while inst_pc=0x004 -> inst_data/inst_pc stable for all 3 cycles, mem_ra=0x004 throughout; next accepted pc is 0x008 with no skips and no duplicates.
- redirect_valid with redirect_pc=0x040 while pc 0x010 is pending -> 0x010 never accepted; 0x040 valid 2 cycles later; fetch_cnt excludes 0x010.
- halt_req while pc 0x020 is pending and stalled -> 0x020 delivered once after inst_ready=1, then halted=1 and inst_valid=0; redirect to 0x100 -> halted=0, 0x100 valid 2 cycles later.
- Redirect to 0x1F8 with inst_ready=1 -> inst_pc sequence 0x1F8, 0x1FC, 0x000.
- With IFETCH_MISALIGN_TRAP_EN: redirect_pc=0x042 -> fetch_fault=1, halted=1, no valid; then redirect_pc=0x044 -> fetch_fault=0, 0x044 delivered. Without the macro, redirect_pc=0x042 delivers 0x040.
